// File: rtl/bus_slave_select.sv
// Address-phase front end: shifts in a serial device ID, validates the target slave,
// and drives a registered select/enable to the slave decoder until the transaction ends.
module bus_slave_select #(
  parameter int DEV_ADDR_W = 2,
  parameter int NUM_SLAVES = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  bus_busy,
  input  logic                  mvalid,
  input  logic                  mdata,
  input  logic [NUM_SLAVES-1:0] sready,
  input  logic                  tx_done,
  output logic [DEV_ADDR_W-1:0] sel,
  output logic                  en,
  output logic                  ack,
  output logic                  nack
);

  localparam int CNT_W = $clog2(DEV_ADDR_W + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADDR    = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] CONNECT = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [DEV_ADDR_W-1:0] id;

  logic [DEV_ADDR_W-1:0] id_shift;
  logic [CNT_W-1:0]      cnt_next;
  logic                  id_ok;
  logic                  slave_rdy;

  assign id_shift = (id << 1) | DEV_ADDR_W'(mdata);
  assign cnt_next = cnt + CNT_W'(1);
  assign id_ok    = (32'(id) < NUM_SLAVES);

  // sready is only looked at for in-range IDs, so an out-of-range ID never indexes it
  always_comb begin
    slave_rdy = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (id_ok && (32'(id) == i)) slave_rdy = sready[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      id    <= '0;
      sel   <= '0;
      en    <= 1'b0;
      ack   <= 1'b0;
      nack  <= 1'b0;
    end else begin
      ack  <= 1'b0;
      nack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_busy && mvalid) begin
            id    <= DEV_ADDR_W'(mdata);
            cnt   <= CNT_W'(1);
            state <= (DEV_ADDR_W == 1) ? CHECK : ADDR;
          end
        end
        ADDR: begin
          if (!bus_busy) begin
            state <= IDLE;
            cnt   <= '0;
            id    <= '0;
          end else if (mvalid) begin
            id  <= id_shift;
            cnt <= cnt_next;
            if (cnt_next == CNT_W'(DEV_ADDR_W)) state <= CHECK;
          end
        end
        CHECK: begin
          if (!bus_busy) begin
            state <= IDLE;
            cnt   <= '0;
            id    <= '0;
          end else if (slave_rdy) begin
            sel   <= id;
            en    <= 1'b1;
            ack   <= 1'b1;
            state <= CONNECT;
          end else begin
            nack  <= 1'b1;
            en    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            id    <= '0;
          end
        end
        default: begin
          // payload bits and ready changes while connected belong to the slave
          if (tx_done || !bus_busy) begin
            en    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            id    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_select.sv
// Scoreboard bench for bus_slave_select: expected ack/nack responses are queued when
// an ID is sent and compared when the DUT pulses ack or nack.
module tb_bus_slave_select;

  logic       clk;
  logic       rstn;
  logic       bus_busy;
  logic       mvalid;
  logic       mdata;
  logic [2:0] sready;
  logic       tx_done;
  logic [1:0] sel;
  logic       en;
  logic       ack;
  logic       nack;

  typedef struct {
    logic       acc;
    logic [1:0] sel;
  } resp_t;

  resp_t sb_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;

  bus_slave_select #(.DEV_ADDR_W(2), .NUM_SLAVES(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus_busy (bus_busy),
    .mvalid   (mvalid),
    .mdata    (mdata),
    .sready   (sready),
    .tx_done  (tx_done),
    .sel      (sel),
    .en       (en),
    .ack      (ack),
    .nack     (nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Response monitor: pops one expected response per ack/nack pulse
  always @(negedge clk) begin
    if (rstn && (ack || nack)) begin
      chk("ack_nack_excl", 32'(ack && nack), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        chk("resp_ack", 32'(ack), 32'(e.acc));
        chk("resp_nack", 32'(nack), 32'(!e.acc));
        if (e.acc) chk("resp_sel", 32'(sel), 32'(e.sel));
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    mvalid = 1'b1;
    mdata  = b;
    cyc();
    mvalid = 1'b0;
    mdata  = 1'b0;
    for (int i = 0; i < gap; i++) cyc();
  endtask

  // Sends a 2-bit ID MSB first; checks the one-cycle CHECK gap, the pulse and en level
  task automatic send_id(input logic [1:0] id, input logic [2:0] rdy, input int gap);
    resp_t e;
    logic  ok;
    sready = rdy;
    send_bit(id[1], gap);
    mvalid = 1'b1;
    mdata  = id[0];
    cyc();
    mvalid = 1'b0;
    mdata  = 1'b0;
    ok = (id < 2'd3) && rdy[id];
    e.acc = ok;
    e.sel = id;
    sb_q.push_back(e);
    chk("check_gap_resp", 32'(ack || nack), 32'd0);
    chk("check_gap_en", 32'(en), 32'd0);
    cyc();
    chk("resp_pulse", 32'(ack || nack), 32'd1);
    chk("en_after_check", 32'(en), 32'(ok));
    cyc();
    chk("pulse_one_cycle", 32'(ack || nack), 32'd0);
    chk("en_held", 32'(en), 32'(ok));
  endtask

  task automatic end_tx(input logic [1:0] exp_sel);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("en_after_done", 32'(en), 32'd0);
    chk("sel_retained", 32'(sel), 32'(exp_sel));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; bus_busy = 1'b0; mvalid = 1'b0; mdata = 1'b0;
    sready = 3'b000; tx_done = 1'b0;
    cyc(); cyc();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_nack", 32'(nack), 32'd0);
    rstn = 1'b1;
    cyc();

    // mvalid without bus_busy is ignored
    send_bit(1'b1, 0);
    cyc();
    chk("idle_no_busy_en", 32'(en), 32'd0);

    bus_busy = 1'b1;
    send_id(2'b10, 3'b100, 0);
    chk("accept_sel", 32'(sel), 32'd2);
    end_tx(2'b10);

    send_id(2'b11, 3'b111, 0);
    send_id(2'b01, 3'b111, 0);
    chk("accept2_sel", 32'(sel), 32'd1);
    end_tx(2'b01);

    send_id(2'b00, 3'b110, 0);
    send_id(2'b00, 3'b001, 3);
    chk("gap_sel", 32'(sel), 32'd0);
    end_tx(2'b00);

    // Abort after one bit
    send_bit(1'b1, 0);
    bus_busy = 1'b0;
    cyc();
    chk("abort_en", 32'(en), 32'd0);
    bus_busy = 1'b1;
    cyc();
    send_id(2'b10, 3'b111, 0);
    chk("post_abort_sel", 32'(sel), 32'd2);

    // Connected isolation
    for (int i = 0; i < 8; i++) begin
      mvalid = 1'($urandom_range(0, 1));
      mdata  = 1'($urandom_range(0, 1));
      sready = 3'($urandom_range(0, 7));
      cyc();
      chk("iso_en", 32'(en), 32'd1);
      chk("iso_sel", 32'(sel), 32'd2);
    end
    mvalid = 1'b1; mdata = 1'b1; tx_done = 1'b1;
    cyc();
    mvalid = 1'b0; mdata = 1'b0; tx_done = 1'b0;
    chk("done_vs_bit_en", 32'(en), 32'd0);
    send_id(2'b01, 3'b010, 0);
    chk("no_capture_sel", 32'(sel), 32'd1);

    // Asynchronous reset while connected
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_en", 32'(en), 32'd0);
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_nack", 32'(nack), 32'd0);
    #1 rstn = 1'b1;
    @(negedge clk);
    send_id(2'b10, 3'b100, 0);
    chk("post_rst_sel", 32'(sel), 32'd2);
    end_tx(2'b10);

    cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/bus_slave_select.md
Name: bus_slave_select

Overview:
- Address-phase front end of the system bus slave path. It sits directly upstream of the 3-way slave enable decoder.
- It shifts in the serial device-ID bits that the granted master sends, MSB first, and checks that the target slave exists and is ready.
- It then drives a registered select code and enable to the decoder, and holds them until the transaction ends.
- It returns a one-cycle ack or nack to the master.

Parameters:
- DEV_ADDR_W, 2, number of serial device-ID bits shifted in before a slave is selected.
- NUM_SLAVES, 3, number of valid slaves; an ID >= NUM_SLAVES is rejected.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- bus_busy  input  1  high while the arbiter holds a grant for the current master.
- mvalid  input  1  master serial bit strobe; mdata is sampled on edges where it is high.
- mdata  input  1  master serial address/data bit.
- sready  input  NUM_SLAVES  per-slave ready; bit i refers to slave i.
- tx_done  input  1  single-cycle pulse from the connected slave at transaction completion.
- sel  output  DEV_ADDR_W  registered slave select code to the decoder.
- en  output  1  registered decoder enable; high only while connected.
- ack  output  1  one-cycle pulse: slave accepted.
- nack  output  1  one-cycle pulse: ID invalid or slave not ready.

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous and active-low on rstn.
- Reset values: sel=0, en=0, ack=0, nack=0, state=IDLE, bit counter=0, shift register=0.
- Reset mid-operation: an asserted rstn forces the reset values immediately, in any state, with no clock edge required.
- FSM states: IDLE, ADDR, CHECK, CONNECT.
- IDLE:
  - On an edge with bus_busy=1 and mvalid=1: shift mdata into the ID register LSB, set count=1.
  - Next state is ADDR, or CHECK if DEV_ADDR_W==1.
  - mvalid with bus_busy=0 is ignored.
- ADDR:
  - Each edge with mvalid=1 shifts mdata in (ID = {ID[W-2:0], mdata}) and increments count.
  - When the bit that makes count==DEV_ADDR_W is sampled, next state is CHECK.
  - Edges with mvalid=0 hold state.
  - bus_busy=0 on any edge aborts to IDLE and clears count and ID; no ack or nack is issued.
- CHECK: lasts exactly one cycle. mvalid is ignored.
  - Accept condition: ID < NUM_SLAVES and sready[ID]=1 at that edge.
  - On accept: register sel=ID, en=1, ack=1, and go to CONNECT.
  - Otherwise: nack=1, en=0, sel unchanged, and go to IDLE.
  - bus_busy=0 in CHECK goes to IDLE with no ack or nack.
- Latency: last ID bit sampled at edge k, CHECK occupies cycle k..k+1, ack/nack and en are high starting at edge k+1. ack and nack are high for exactly one cycle and never high together.
- CONNECT:
  - en=1 and sel held constant.
  - mvalid/mdata are ignored, since they carry payload for the slave.
  - sready changes are ignored.
  - On an edge with tx_done=1 or bus_busy=0: en=0, go to IDLE, clear count and ID.
  - sel retains its last value after exit; downstream gating uses en only.
- Simultaneous events:
  - tx_done and mvalid on the same edge in CONNECT: exit wins and the bit is not captured.
  - A new transaction's first bit can be accepted on the edge after returning to IDLE at the earliest.
- Width rules:
  - The ID comparison is unsigned DEV_ADDR_W-bit.
  - sready is indexed only when ID < NUM_SLAVES; out-of-range IDs never index sready.
  - The bit counter is wide enough to hold DEV_ADDR_W without wrap.

Test Plan:
- Reset during CONNECT (en=1): drop rstn between edges -> en, sel, ack, nack are 0 immediately; after release, state is IDLE and the next bit starts a fresh ID.
- Accept: bus_busy=1, mvalid bits 1,0 on consecutive edges, sready=3'b100 -> CHECK one cycle, then ack=1 for one cycle, sel=2'b10, en=1 held. tx_done pulse -> en=0 on the next edge.
- Invalid ID: bits 1,1 with sready=3'b111 -> nack=1 for one cycle, en stays 0, return to IDLE. Follow with bits 0,1 -> ack, sel=2'b01.
- Not ready and gaps: bits 0,0 with sready=3'b110 -> nack. Repeat with mvalid gaps of 3 idle cycles between bits and sready=3'b001 -> gaps tolerated, ack, sel=0.
- Abort: bit 1 sampled, then bus_busy=0 before the second bit -> IDLE with no ack or nack. Next bits 1,0 decode as sel=2'b10, not corrupted by the stale bit.
- Connected isolation: in CONNECT toggle mvalid/mdata for 8 cycles and change sready -> sel and en unchanged. tx_done and mvalid on the same edge -> en=0, no capture; ID register is 0 afterwards.
